// File: rtl/axi_lite_prog_master.sv
// rtl/axi_lite_prog_master.sv - AXI4-Lite master executing write/read/poll commands
// One command in flight; response held until consumed.
module axi_lite_prog_master #(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 5,
  parameter int POLL_TIMEOUT         = 1024,
  parameter int POLL_GAP             = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_awaddr,
  output logic                            m00_axi_awvalid,
  input  logic                            m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_wdata,
  output logic                            m00_axi_wvalid,
  input  logic                            m00_axi_wready,
  input  logic [1:0]                      m00_axi_bresp,
  input  logic                            m00_axi_bvalid,
  output logic                            m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready
);

  localparam logic [1:0]  OP_WR       = 2'b00;
  localparam logic [1:0]  OP_RD       = 2'b01;
  localparam logic [1:0]  OP_POLL     = 2'b10;
  localparam logic [31:0] TIMEOUT_LIM = 32'(POLL_TIMEOUT);
  localparam logic [31:0] GAP_LIM     = 32'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_D, S_GAP, S_RSP
  } state_t;

  state_t                            state, state_next;
  logic [1:0]                        op_q;
  logic [C_M00_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M00_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                              aw_done, w_done;
  logic [31:0]                       poll_cnt, gap_cnt;
  logic [C_M00_AXI_DATA_WIDTH-1:0]   rsp_data_q;
  logic [1:0]                        rsp_resp_q;
  logic                              rsp_timeout_q;

  logic live;
  logic aw_hs, w_hs;
  logic poll_match, poll_last, poll_timeout_hit, beat_final;

  // Outputs are forced low during the reset cycle itself, not only after it.
  assign live            = !s00_axi_reset;
  assign cmd_ready       = live && (state == S_IDLE);
  assign rsp_valid       = live && (state == S_RSP);
  assign rsp_data        = live ? rsp_data_q : '0;
  assign rsp_resp        = live ? rsp_resp_q : 2'b00;
  assign rsp_timeout     = live && rsp_timeout_q;
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_wdata   = wdata_q;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_awvalid = live && (state == S_WR) && !aw_done;
  assign m00_axi_wvalid  = live && (state == S_WR) && !w_done;
  assign m00_axi_bready  = live && (state == S_WR_B);
  assign m00_axi_arvalid = live && (state == S_RD_A);
  assign m00_axi_rready  = live && (state == S_RD_D);

  assign aw_hs = m00_axi_awvalid && m00_axi_awready;
  assign w_hs  = m00_axi_wvalid && m00_axi_wready;

  assign poll_match       = (m00_axi_rdata & wdata_q) == wdata_q;
  assign poll_last        = (TIMEOUT_LIM != 32'd0) && ((poll_cnt + 32'd1) == TIMEOUT_LIM);
  assign poll_timeout_hit = (op_q == OP_POLL) && (m00_axi_rresp == 2'b00) && !poll_match && poll_last;
  assign beat_final       = (op_q != OP_POLL) || (m00_axi_rresp != 2'b00) || poll_match || poll_last;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WR:          state_next = S_WR;
            OP_RD, OP_POLL: state_next = S_RD_A;
            default:        state_next = S_RSP;
          endcase
        end
      end
      S_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = S_WR_B;
      S_WR_B: if (m00_axi_bvalid) state_next = S_RSP;
      S_RD_A: if (m00_axi_arready) state_next = S_RD_D;
      S_RD_D: if (m00_axi_rvalid) state_next = beat_final ? S_RSP : S_GAP;
      S_GAP:  if (gap_cnt == GAP_LIM) state_next = S_RD_A;
      S_RSP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_reset) begin
      state         <= S_IDLE;
      op_q          <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q          <= cmd_op;
            addr_q        <= cmd_addr;
            wdata_q       <= cmd_wdata;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            poll_cnt      <= '0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= (cmd_op == 2'b11) ? 2'b10 : 2'b00;
            rsp_timeout_q <= 1'b0;
          end
        end
        S_WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        S_WR_B: begin
          if (m00_axi_bvalid) rsp_resp_q <= m00_axi_bresp;
        end
        S_RD_D: begin
          // Every beat is captured; only the final one is ever presented.
          if (m00_axi_rvalid) begin
            rsp_data_q    <= m00_axi_rdata;
            rsp_resp_q    <= m00_axi_rresp;
            rsp_timeout_q <= poll_timeout_hit;
            poll_cnt      <= poll_cnt + 32'd1;
            gap_cnt       <= '0;
          end
        end
        S_GAP: gap_cnt <= gap_cnt + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_prog_master.sv
// tb/tb_axi_lite_prog_master.sv - scoreboard bench for axi_lite_prog_master
module tb_axi_lite_prog_master;
  localparam int PTO  = 8;
  localparam int PGAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_addr = 5'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  axi_lite_prog_master #(
    .C_M00_AXI_DATA_WIDTH(32), .C_M00_AXI_ADDR_WIDTH(5),
    .POLL_TIMEOUT(PTO), .POLL_GAP(PGAP)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m00_axi_awaddr(awaddr), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  typedef struct packed { logic [1:0] resp; logic [31:0] data; } rd_t;
  typedef struct {
    logic [31:0] data; logic [1:0] resp; logic tmo;
    int n_aw; int n_w; int n_ar; int lat;
  } exp_t;

  int checks = 0, errors = 0, cyc = 0, rsp_total = 0;
  exp_t exp_q[$];
  rd_t  script_q[$];
  logic [31:0] ref_mem [8] = '{default: 32'd0};
  logic [31:0] slave_mem [8] = '{default: 32'd0};
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0, rsp_hold = 0;
  logic [1:0] bresp_cfg = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference: what the slave will return for the k-th read of a command.
  function automatic rd_t peek(input int k, input logic [4:0] a);
    rd_t v;
    if (k < script_q.size()) return script_q[k];
    v.resp = 2'b00;
    v.data = ref_mem[a[4:2]];
    return v;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd);
    exp_t e;
    rd_t  v;
    e.data = 32'd0; e.resp = 2'b00; e.tmo = 1'b0;
    e.n_aw = 0; e.n_w = 0; e.n_ar = 0; e.lat = 0;
    case (op)
      2'b00: begin e.resp = bresp_cfg; e.n_aw = 1; e.n_w = 1; ref_mem[a[4:2]] = wd; end
      2'b01: begin v = peek(0, a); e.data = v.data; e.resp = v.resp; e.n_ar = 1; end
      2'b10: begin
        for (int k = 0; k < 64; k++) begin
          v = peek(k, a);
          e.n_ar = k + 1; e.data = v.data; e.resp = v.resp;
          if (v.resp != 2'b00 || (v.data & wd) == wd) break;
          if (e.n_ar == PTO) begin e.tmo = 1'b1; break; end
        end
      end
      default: e.resp = 2'b10;
    endcase
    return e;
  endfunction

  // Slave model, response consumer and monitor, all acting on the falling edge.
  logic        aw_got = 0, w_got = 0, b_active = 0, r_active = 0;
  logic [4:0]  aw_addr_l = 0, r_addr_l = 0;
  logic [31:0] w_data_l = 0, r_data_l = 0, p_rd = 0;
  logic [1:0]  r_resp_l = 0, p_rresp = 0;
  logic        aw_hs_p = 0, w_hs_p = 0, b_hs_p = 0, ar_hs_p = 0, r_hs_p = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic        p_rv = 0, p_rr = 0, p_tmo = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;
  int n_aw = 0, n_w = 0, n_ar = 0, acc_cyc = 0, rise_cyc = 0, last_ar_cyc = 0, ar_in_cmd = 0;
  rd_t  popped;
  exp_t e_m;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rsp_ready = 0;
      aw_got = 0; w_got = 0; b_active = 0; r_active = 0;
      aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; rsp_cnt = 0;
      n_aw = 0; n_w = 0; n_ar = 0; ar_in_cmd = 0;
    end else begin
      if (p_awv && !p_awr) chk1("awvalid_hold", awvalid, 1'b1);
      if (p_wv && !p_wr)   chk1("wvalid_hold", wvalid, 1'b1);
      if (p_arv && !p_arr) chk1("arvalid_hold", arvalid, 1'b1);

      if (aw_hs_p) aw_got = 1;
      if (w_hs_p)  w_got = 1;
      if (aw_got && w_got) begin
        slave_mem[aw_addr_l[4:2]] = w_data_l;
        aw_got = 0; w_got = 0; b_active = 1; b_cnt = 0;
      end
      if (b_hs_p) begin b_active = 0; bvalid = 0; end
      if (ar_hs_p) begin
        r_active = 1; r_cnt = 0;
        if (script_q.size() > 0) begin
          popped = script_q.pop_front();
          r_data_l = popped.data; r_resp_l = popped.resp;
        end else begin
          r_data_l = slave_mem[r_addr_l[4:2]]; r_resp_l = 2'b00;
        end
      end
      if (r_hs_p) begin r_active = 0; rvalid = 0; end
      if (cmd_valid && cmd_ready) begin acc_cyc = cyc; ar_in_cmd = 0; end

      awready = awvalid && (aw_cnt >= aw_delay);
      if (awvalid && !awready) aw_cnt++;
      aw_hs_p = awvalid && awready;
      if (aw_hs_p) begin aw_cnt = 0; aw_addr_l = awaddr; n_aw++; end

      wready = wvalid && (w_cnt >= w_delay);
      if (wvalid && !wready) w_cnt++;
      w_hs_p = wvalid && wready;
      if (w_hs_p) begin w_cnt = 0; w_data_l = wdata; n_w++; end

      if (b_active && !bvalid) begin
        if (b_cnt >= b_delay) begin bvalid = 1; bresp = bresp_cfg; end
        else b_cnt++;
      end
      if (bready) chk1("bready_after_aw_w", b_active, 1'b1);
      b_hs_p = bvalid && bready;

      arready = arvalid && (ar_cnt >= ar_delay);
      if (arvalid && !arready) ar_cnt++;
      ar_hs_p = arvalid && arready;
      if (ar_hs_p) begin
        ar_cnt = 0; r_addr_l = araddr; n_ar++;
        if (ar_in_cmd > 0) chk1("poll_gap", (cyc - last_ar_cyc - 1) >= PGAP, 1'b1);
        last_ar_cyc = cyc; ar_in_cmd++;
      end

      if (r_active && !rvalid) begin
        if (r_cnt >= r_delay) begin rvalid = 1; rdata = r_data_l; rresp = r_resp_l; end
        else r_cnt++;
      end
      if (rready) chk1("rready_after_ar", r_active, 1'b1);
      r_hs_p = rvalid && rready;

      if (p_rv && !p_rr) begin
        chk1("rsp_valid_hold", rsp_valid, 1'b1);
        chk("rsp_data_stable", rsp_data, p_rd);
        chk("rsp_resp_stable", 32'(rsp_resp), 32'(p_rresp));
        chk1("rsp_timeout_stable", rsp_timeout, p_tmo);
      end
      if (rsp_valid) chk1("cmd_ready_in_rsp", cmd_ready, 1'b0);
      if (rsp_valid && !p_rv) rise_cyc = cyc;
      rsp_ready = rsp_valid && (rsp_cnt >= rsp_hold);
      if (rsp_valid && !rsp_ready) rsp_cnt++;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt = 0; rsp_total++;
        if (exp_q.size() == 0) chk1("unexpected_rsp", 1'b1, 1'b0);
        else begin
          e_m = exp_q.pop_front();
          chk("rsp_data", rsp_data, e_m.data);
          chk("rsp_resp", 32'(rsp_resp), 32'(e_m.resp));
          chk1("rsp_timeout", rsp_timeout, e_m.tmo);
          chk("aw_count", n_aw, e_m.n_aw);
          chk("w_count", n_w, e_m.n_w);
          chk("ar_count", n_ar, e_m.n_ar);
          if (e_m.lat > 0) chk("latency", rise_cyc - acc_cyc, e_m.lat);
        end
        n_aw = 0; n_w = 0; n_ar = 0;
      end
      p_rv = rsp_valid; p_rr = rsp_ready; p_rd = rsp_data; p_rresp = rsp_resp; p_tmo = rsp_timeout;
      p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready; p_arv = arvalid; p_arr = arready;
    end
  end

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd, input int lat);
    exp_t e;
    int   base;
    logic ok;
    e = model(op, a, wd);
    e.lat = lat;
    exp_q.push_back(e);
    base = rsp_total;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = cmd_ready; end
    chk1("cmd_accept", ok, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 0;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin @(negedge clk); ok = (rsp_total > base); end
    chk1("rsp_arrived", ok, 1'b1);
  endtask

  task automatic push_rd(input logic [1:0] r, input logic [31:0] d);
    rd_t v;
    v.resp = r; v.data = d;
    script_q.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [4:0]  a;
    logic [31:0] wd;
    int          base, n;
    rd_t         sv;

    @(negedge clk);
    chk1("reset_cmd_ready", cmd_ready, 1'b0);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    chk1("reset_awvalid", awvalid, 1'b0);
    chk1("reset_wvalid", wvalid, 1'b0);
    chk1("reset_bready", bready, 1'b0);
    chk1("reset_arvalid", arvalid, 1'b0);
    chk1("reset_rready", rready, 1'b0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_resp", 32'(rsp_resp), 32'd0);
    chk1("reset_rsp_timeout", rsp_timeout, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk1("idle_cmd_ready", cmd_ready, 1'b1);

    send(2'b00, 5'h14, 32'h0050_0093, 3);
    aw_delay = 3;
    send(2'b00, 5'h08, 32'hCAFE_0001, 0);
    aw_delay = 0;
    send(2'b00, 5'h00, 32'h0000_0002, 3);
    r_delay = 5;
    send(2'b01, 5'h00, 32'd0, 0);
    r_delay = 0;
    send(2'b01, 5'h14, 32'd0, 3);

    script_q.delete();
    push_rd(2'b00, 32'h0); push_rd(2'b00, 32'h0); push_rd(2'b00, 32'h0); push_rd(2'b00, 32'h4);
    send(2'b10, 5'h04, 32'h4, 0);

    script_q.delete();
    for (int k = 0; k < 8; k++) push_rd(2'b00, 32'h0);
    send(2'b10, 5'h04, 32'hFFFF_FFFF, 0);

    script_q.delete();
    push_rd(2'b00, 32'h1); push_rd(2'b00, 32'h3); push_rd(2'b10, 32'h0000_DEAD);
    send(2'b10, 5'h04, 32'h4, 0);
    script_q.delete();

    bresp_cfg = 2'b10; rsp_hold = 3;
    send(2'b00, 5'h0C, 32'h0000_1234, 0);
    bresp_cfg = 2'b00; rsp_hold = 0;

    aw_delay = 50; w_delay = 50;
    base = rsp_total;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = 2'b00; cmd_addr = 5'h10; cmd_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk1("rst_cycle_awvalid", awvalid, 1'b0);
    chk1("rst_cycle_wvalid", wvalid, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk1("post_rst_awvalid", awvalid, 1'b0);
    chk1("post_rst_wvalid", wvalid, 1'b0);
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);
    repeat (10) @(negedge clk);
    chk("no_rsp_after_reset", rsp_total, base);
    aw_delay = 0; w_delay = 0;

    send(2'b11, 5'h1F, 32'h0, 0);
    send(2'b01, 5'h10, 32'h0, 0);

    for (int t = 0; t < 40; t++) begin
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 5'($urandom);
      wd = $urandom;
      aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4);
      b_delay  = $urandom_range(0, 4); ar_delay = $urandom_range(0, 4);
      r_delay  = $urandom_range(0, 4); rsp_hold = $urandom_range(0, 3);
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      script_q.delete();
      if (op == 2'b10) begin
        wd = $urandom & $urandom & $urandom;
        n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++) begin
          sv.resp = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          sv.data = $urandom;
          if ($urandom_range(0, 5) == 0) sv.data = sv.data | wd;
          script_q.push_back(sv);
        end
      end else if (op == 2'b01 && $urandom_range(0, 3) == 0) begin
        sv.resp = 2'($urandom); sv.data = $urandom;
        script_q.push_back(sv);
      end
      send(op, a, wd, 0);
    end

    repeat (5) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
